// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by i_fetch and ifetch_fifo.
package ifetch_pkg;

    localparam int          INSTR_W    = 32;
    localparam int          PC_W       = 32;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] EMPTY_WORD = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and combinational head read.
// DEPTH must be a power of two so the pointers wrap on their own.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head_entry,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] wr_en;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && !flush && (wr_ptr_q == PTR_W'(gi));
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the consumer masks the head while count is zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_q[i] <= wr_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch: PC register, prefetch buffer control and redirect handling.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module i_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic             err_q, err_d;
    logic             push, pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry, head_entry;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    // Full buffer may still accept a word when the head leaves this cycle.
    assign push        = !redirect_valid && !err_q
                         && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            pc_d  = redirect_pc;
            err_d = (redirect_pc[1:0] != 2'b00);
`else
            pc_d  = redirect_pc & ~32'h3;
            err_d = 1'b0;
`endif
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign wr_entry.instr = imem_data;
    assign wr_entry.pc    = pc_q;

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .wr_entry  (wr_entry),
        .head_entry(head_entry),
        .count     (count)
    );

    assign imem_addr = pc_q;
    assign instr_out = instr_valid ? head_entry.instr : EMPTY_WORD;
    assign instr_pc  = instr_valid ? head_entry.pc    : EMPTY_WORD;
    assign instr_pc4 = instr_pc + PC_STEP;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed vector table, then randomized run
// against a queue-based reference model.
module tb_i_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam int          NVEC       = 20;
    localparam int          NRAND      = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        misalign_err_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory word k (byte address 4k) holds 32'h1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign imem_data = mem_word(imem_addr);

    i_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_pc4     (instr_pc4)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err  (misalign_err_w)
`endif
    );

`ifndef IFETCH_MISALIGN_TRAP_EN
    assign misalign_err_w = 1'b0;
`endif

    // Reference model: the buffer is a queue of fetched PCs.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_err;

    task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        if (r) begin
            m_q.delete();
            m_pc  = RESET_PC;
            m_err = 1'b0;
            return;
        end
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (rv) begin
            m_q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            m_pc  = rpc;
            m_err = (rpc % 4) != 0;
`else
            m_pc  = rpc - (rpc % 4);
`endif
        end else if (!m_err && m_q.size() < FIFO_DEPTH) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic apply(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clk);
        model_step(r, rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic e_valid,
                                 input logic [31:0] e_pc, input logic [31:0] e_addr,
                                 input logic e_err);
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        e_ipc   = e_valid ? e_pc : 32'h0;
        e_instr = e_valid ? mem_word(e_pc) : 32'h0;
        check({tag, ".valid"}, idx, {31'h0, instr_valid}, {31'h0, e_valid});
        check({tag, ".addr"},  idx, imem_addr, e_addr);
        check({tag, ".pc"},    idx, instr_pc, e_ipc);
        check({tag, ".instr"}, idx, instr_out, e_instr);
        check({tag, ".pc4"},   idx, instr_pc4, e_ipc + 32'd4);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check({tag, ".err"},   idx, {31'h0, misalign_err_w}, {31'h0, e_err});
`else
        if (e_err) check({tag, ".err"}, idx, 32'h1, 32'h0);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_err;
    } vec_t;

    vec_t vt[NVEC];

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] ea, input logic ee);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_addr = ea; v.e_err = ee;
        return v;
    endfunction

    initial begin
        //          rst   rv    rpc            rdy   valid pc             addr           err
        vt[0]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b0);
        vt[1]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4,         1'b0);
        vt[2]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
        vt[3]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
        vt[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
        vt[5]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         1'b0);
        vt[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'hC,         1'b0);
        vt[7]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h10,        1'b0);
        vt[8]  = mk(1'b0, 1'b1, 32'h40,        1'b1, 1'b0, 32'h0,         32'h40,        1'b0);
        vt[9]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h44,        1'b0);
        vt[10] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h44,        32'h48,        1'b0);
        vt[11] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0);
        vt[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         1'b0);
        vt[14] = mk(1'b1, 1'b1, 32'h80,        1'b1, 1'b0, 32'h0,         RESET_PC,      1'b0);
        vt[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        vt[16] = mk(1'b0, 1'b1, 32'h42,        1'b1, 1'b0, 32'h0,         32'h42,        1'b1);
        vt[17] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h42,        1'b1);
`else
        vt[16] = mk(1'b0, 1'b1, 32'h42,        1'b1, 1'b0, 32'h0,         32'h40,        1'b0);
        vt[17] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h44,        1'b0);
`endif
        vt[18] = mk(1'b0, 1'b1, 32'h44,        1'b1, 1'b0, 32'h0,         32'h44,        1'b0);
        vt[19] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h44,        32'h48,        1'b0);

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        m_pc           = RESET_PC;
        m_err          = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            apply(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy);
            check_outputs("vec", i, vt[i].e_valid, vt[i].e_pc, vt[i].e_addr, vt[i].e_err);
            $display("vec %0d: rst=%0b rv=%0b rpc=%h rdy=%0b -> valid=%0b pc=%h addr=%h",
                     i, vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy,
                     instr_valid, instr_pc, imem_addr);
        end

        apply(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < NRAND; i++) begin
            logic        r, rv, rdy;
            logic [31:0] rpc;
            int unsigned sel;
            r   = ($urandom_range(0, 99) < 2);
            rv  = ($urandom_range(0, 99) < 12);
            rdy = ($urandom_range(0, 99) < 60);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rpc = $urandom & 32'h0000_0FFC;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                2:       rpc = $urandom & 32'h0000_0FFF;
                default: rpc = $urandom;
            endcase
            apply(r, rv, rpc, rdy);
            check_outputs("rand", i, m_q.size() != 0,
                          (m_q.size() != 0) ? m_q[0] : 32'h0, m_pc, m_err);
            $display("rand %0d: rst=%0b rv=%0b rpc=%h rdy=%0b -> valid=%0b pc=%h addr=%h",
                     i, r, rv, rpc, rdy, instr_valid, instr_pc, imem_addr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction fetch unit driving the instruction memory's read port. It holds the program counter and presents byte addresses to the memory. It captures the returned 32-bit word together with its PC into a small prefetch buffer, and hands instructions to decode over a valid/ready handshake. Branch/jump redirects from later stages flush the buffer and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word; combinational function of imem_addr, valid the same cycle.
- redirect_valid  in  1  load a new PC and flush the buffer.
- redirect_pc  in  32  redirect target, byte address.
- instr_valid  out  1  buffer head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr_out  out  32  instruction at the buffer head.
- instr_pc  out  32  byte address of instr_out.
- instr_pc4  out  32  instr_pc + 4, mod 2^32.

## Operation
- Buffer: FIFO of {instr, pc}, occupancy count 0..FIFO_DEPTH.
  - push = !redirect_valid && (count < FIFO_DEPTH || pop).
  - pop = instr_valid && instr_ready.
- Push:
  - Write {imem_data, pc} at the tail.
  - pc <= pc + 4, 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
- No push: pc holds; imem_addr stays stable.
- Pop: head advances. A pop and a push in the same cycle leave count unchanged; this is legal even when the buffer is full.
- Redirect has priority over push:
  - pc <= redirect_pc.
  - Buffer flushed: count <= 0, pointers to 0.
  - A pop in the redirect cycle is still a completed transfer for decode.
  - The fetch word present in the redirect cycle is discarded.
- instr_valid = (count != 0). instr_out, instr_pc and instr_pc4 come from the head entry; they read 0 when empty.
- Misaligned redirect targets are handled per Configuration.

## Timing
- Reset values:
  - pc = imem_addr = RESET_PC.
  - count = 0, instr_valid = 0.
  - instr_out = instr_pc = 0, instr_pc4 = 4.
  - misalign_err = 0 (when present).
- rst asserted mid-operation wins over redirect, push and pop in that cycle.
- First instr_valid comes one cycle after rst deasserts: the push happens in cycle 0, valid is seen in cycle 1.
- Redirect latency:
  - redirect_valid in cycle N.
  - imem_addr = target in N+1.
  - instr_valid with instr_pc = target in N+2.
- With instr_ready held high and no redirects, throughput is one instruction per cycle.
- instr_* outputs are registered or FIFO-head reads. There is no combinational path from instr_ready or redirect_valid to instr_*.

## Configuration
- Macro IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (out, 1).
  - A redirect with redirect_pc[1:0] != 0 sets misalign_err (sticky), loads pc and flushes the buffer.
  - Fetch then stops (no pushes) until reset or an aligned redirect, which clears misalign_err.
- Undefined:
  - No misalign_err port.
  - redirect_pc[1:0] is ignored; pc <= {redirect_pc[31:2], 2'b00}.

## Structure
- Package ifetch_pkg holds:
  - INSTR_W = 32, PC_W = 32, PC_STEP = 32'd4.
  - typedef fetch_entry_t {instr, pc}.
  - Empty-output constant 32'h0.
- One sub-module, ifetch_fifo: parameterised synchronous FIFO with push/pop/flush, count, and combinational head read.
- i_fetch owns the PC register, push/pop control and misalign logic.

## Test plan
- Reset with RESET_PC=0, memory word k = 32'h1000_0000+k, instr_ready=1:
  - instr_pc = 0, 4, 8, … on consecutive cycles from cycle 1.
  - instr_out = 32'h1000_0000, 32'h1000_0001, …
- Backpressure: instr_ready=0 for 5 cycles.
  - count saturates at 2; imem_addr holds at 8.
  - On release, instr_pc continues 0, 4, 8 with no gap or duplicate.
- Redirect to 32'h40 while the buffer is full and instr_ready=1:
  - Head pc=0 is accepted in that cycle.
  - Next valid instruction has instr_pc = 32'h40, two cycles later.
  - Buffered pc=4 is never presented.
- Wrap-around: redirect to 32'hFFFF_FFFC.
  - instr_pc = 32'hFFFF_FFFC, then 32'h0.
  - instr_pc4 = 32'h0 on the first.
- rst asserted together with redirect_valid to 32'h80:
  - Next cycle imem_addr = RESET_PC and instr_valid = 0.
- Misaligned redirect to 32'h42:
  - With IFETCH_MISALIGN_TRAP_EN: misalign_err = 1, instr_valid stays 0. A following redirect to 32'h44 clears misalign_err, and instr_pc = 32'h44 follows.
  - Without the macro: instr_pc = 32'h40.
